rng_arb_ctrl: RTL
=================

RNG_ARB_CTRL -- requirements
Module: rng_arb_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning random word and seed width.
REQ-003 SHALL have parameter DECIM_WIDTH, default 4, meaning width of the decimation count.
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 SHALL have the following ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- en_i  in  1  arbitration enable.
- decim_i  in  DECIM_WIDTH  extra LFSR steps discarded per delivery.
- seed_wr_i  in  1  seed-write pulse.
- seed_dat_i  in  DATA_WIDTH  seed value.
- req_i  in  NUM_REQ  per-requester request, level, held until granted.
- gnt_o  out  NUM_REQ  one-hot grant, one cycle.
- dat_o  out  DATA_WIDTH  random word, valid only while gnt_o != 0, else 0.
- lfsr_adv_o  out  1  advance LFSR one step.
- lfsr_wr_o  out  1  load LFSR with lfsr_dat_o.
- lfsr_dat_o  out  DATA_WIDTH  seed to LFSR, 0 when lfsr_wr_o=0.
- lfsr_dat_i  in  DATA_WIDTH  current LFSR state.
- busy_o  out  1  state != IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, SEED, STEP, GRANT, held in a register.
REQ-007 IDLE: pending seed SHALL take priority -> SEED; else if en_i=1 and req_i!=0 -> STEP; else stay IDLE.
REQ-008 On the IDLE->STEP transition, the block SHALL latch the round-robin winner and load step counter with decim_i; later decim_i changes are ignored until next arbitration.
REQ-009 Round-robin SHALL search from (last_winner+1) mod NUM_REQ upward with wrap-around; last_winner SHALL update on IDLE->STEP.
REQ-010 STEP: lfsr_adv_o=1 every cycle; counter decrements; when counter=0 in a STEP cycle -> GRANT, so STEP lasts exactly decim_i+1 cycles.
REQ-011 GRANT lasts one cycle: lfsr_adv_o=0, gnt_o=onehot(winner), dat_o=lfsr_dat_i; next state IDLE.
REQ-012 Latency: req_i first sampled in IDLE at cycle T -> gnt_o asserted in cycle T+2+decim_i.
REQ-013 Minimum spacing between grants SHALL be decim_i+3 cycles (IDLE, STEP x(decim_i+1), GRANT).
REQ-014 req_i deasserted before grant is a protocol violation; the latched grant SHALL still be issued.
REQ-015 seed_wr_i=1 with seed_dat_i!=0 SHALL write the pending-seed register and set pending, in any state; a later write overwrites an earlier pending value.
REQ-016 seed_wr_i=1 with seed_dat_i=0 SHALL be ignored (LFSR lock-up prevention).
REQ-017 SEED lasts one cycle: lfsr_wr_o=1, lfsr_dat_o=pending seed, pending cleared; next state IDLE. A non-zero seed_wr_i in that same cycle SHALL leave pending set with the new value.
REQ-018 Seeds arriving during STEP/GRANT SHALL be deferred to the next IDLE; an in-flight delivery is never interrupted.
REQ-019 en_i=0 SHALL block only new arbitration; an in-flight STEP/GRANT completes and pending seeds are still applied.
REQ-020 lfsr_adv_o and lfsr_wr_o SHALL never be asserted in the same cycle.
REQ-021 gnt_o, dat_o, lfsr_*_o and busy_o SHALL decode from registered state only, with no combinational path from req_i.

Reset
REQ-022 On a clk_i edge with rst_n_i=0: state=IDLE, last_winner=NUM_REQ-1 so req 0 wins first, counter=0, pending=0, pending seed=0.
REQ-023 During and after reset, until the next transition: gnt_o=0, dat_o=0, lfsr_adv_o=0, lfsr_wr_o=0, lfsr_dat_o=0, busy_o=0.
REQ-024 Reset asserted mid-STEP or GRANT SHALL abort the transaction with no grant issued and drop any pending seed.

Verification
REQ-025 Single request: decim_i=2, req_i=4'b0100 at T -> lfsr_adv_o high for T+1..T+3, gnt_o=4'b0100 and dat_o=lfsr_dat_i at T+4.
REQ-026 Fairness: req_i=4'b1111 held with decim_i=0 -> grants 0,1,2,3,0 every 3 cycles.
REQ-027 Seed priority: seed_wr_i=1, seed_dat_i=32'h1234_5678 plus req_i=4'b0001 in IDLE -> lfsr_wr_o=1 with lfsr_dat_o=32'h1234_5678 next cycle, then STEP.
REQ-028 Zero seed: seed_wr_i=1, seed_dat_i=0 -> lfsr_wr_o never asserted.
REQ-029 Deferred seed: seed written during STEP -> grant completes first, then SEED cycle.
REQ-030 Reset mid-STEP: rst_n_i=0 for 1 cycle during STEP -> no gnt_o; after reset, req_i=4'b1010 -> req 1 granted first.

Source files
------------

// File: rtl/rng_arb_ctrl.sv
// Round-robin arbiter that hands out one LFSR word per grant, discarding
// decim_i extra LFSR steps before each delivery and applying non-zero seeds.
module rng_arb_ctrl #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int DECIM_WIDTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   en_i,
   input  logic [DECIM_WIDTH-1:0] decim_i,
   input  logic                   seed_wr_i,
   input  logic [DATA_WIDTH-1:0]  seed_dat_i,
   input  logic [NUM_REQ-1:0]     req_i,
   output logic [NUM_REQ-1:0]     gnt_o,
   output logic [DATA_WIDTH-1:0]  dat_o,
   output logic                   lfsr_adv_o,
   output logic                   lfsr_wr_o,
   output logic [DATA_WIDTH-1:0]  lfsr_dat_o,
   input  logic [DATA_WIDTH-1:0]  lfsr_dat_i,
   output logic                   busy_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, SEED, STEP, GRANT} state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [DECIM_WIDTH-1:0] cnt_q, cnt_d;
   logic                   pend_q, pend_d;
   logic [DATA_WIDTH-1:0]  seed_q, seed_d;

   logic                   seed_ok;
   logic                   rr_found;
   logic [IDX_W-1:0]       rr_idx;

   assign seed_ok = seed_wr_i && (seed_dat_i != '0);

   // Scan offsets from farthest to nearest so the nearest requester after
   // last_q is the final assignment and therefore wins.
   always_comb begin
      int unsigned idx;
      rr_idx   = last_q;
      rr_found = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last_q) + k) % NUM_REQ;
         if (req_i[IDX_W'(idx)]) begin
            rr_idx   = IDX_W'(idx);
            rr_found = 1'b1;
         end
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      seed_d  = seed_q;
      case (state_q)
         IDLE: begin
            if (pend_q || seed_ok) begin
               state_d = SEED;
            end else if (en_i && rr_found) begin
               state_d = STEP;
               last_d  = rr_idx;
               cnt_d   = decim_i;
            end
         end
         SEED: begin
            pend_d  = 1'b0;
            state_d = IDLE;
         end
         STEP: begin
            if (cnt_q == '0) state_d = GRANT;
            else             cnt_d   = cnt_q - 1'b1;
         end
         GRANT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A fresh seed wins over the SEED-cycle clear, so back-to-back writes
      // are never lost.
      if (seed_ok) begin
         pend_d = 1'b1;
         seed_d = seed_dat_i;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         last_q  <= IDX_W'(NUM_REQ - 1);
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         seed_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         seed_q  <= seed_d;
      end
   end

   // Outputs are held quiet while reset is asserted so an aborted GRANT
   // never leaks a grant in the reset cycle.
   assign busy_o     = rst_n_i && (state_q != IDLE);
   assign lfsr_adv_o = rst_n_i && (state_q == STEP);
   assign lfsr_wr_o  = rst_n_i && (state_q == SEED);
   assign lfsr_dat_o = (rst_n_i && state_q == SEED) ? seed_q : '0;
   assign gnt_o      = (rst_n_i && state_q == GRANT)
                       ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << last_q) : '0;
   assign dat_o      = (rst_n_i && state_q == GRANT) ? lfsr_dat_i : '0;

endmodule
